// File: rtl/data_mem_port_pkg.sv
// Shared definitions for the MEM-stage data port: access-size encodings,
// byte-enable patterns, FSM state type and the lane/alignment helpers.
package data_mem_port_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Size 2'b11 is treated as a word everywhere.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: return BE_BYTE << lane;
            SIZE_HALF: return BE_HALF << {lane[1], 1'b0};
            default:   return BE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lane[0];
            default:   return lane != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_lane.sv
// Combinational lane unit: byte enables, store-data replication and
// load-data extraction with sign/zero extension (little-endian lanes).
module data_mem_lane
    import data_mem_port_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        load_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        sign_fill;

    always_comb begin
        // NOTE: every output gets a value before the case so no path leaves a latch behind.
        byte_en   = byte_enable(size, lane);
        bus_wdata = store_data;
        load_data = bus_rdata;
        load_byte = bus_rdata[{lane, 3'b000} +: 8];
        load_half = bus_rdata[{lane[1], 4'b0000} +: 16];
        sign_fill = 1'b0;

        case (size)
            SIZE_BYTE: begin
                bus_wdata = {4{store_data[7:0]}};
                sign_fill = load_byte[7] & ~load_unsigned;
                load_data = {{24{sign_fill}}, load_byte};
            end
            SIZE_HALF: begin
                bus_wdata = {2{store_data[15:0]}};
                sign_fill = load_half[15] & ~load_unsigned;
                load_data = {{16{sign_fill}}, load_half};
            end
            SIZE_WORD, 2'b11: begin
                bus_wdata = store_data;
                load_data = bus_rdata;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_port.sv
// MEM-stage load/store port: turns decoded loads/stores into aligned word-bus
// transactions and stalls the pipeline until done. Optional DATA_MEM_ALIGN_CHECK_EN
// rejects misaligned half/word accesses with BusError instead of issuing them.
module data_mem_port
    import data_mem_port_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              MemoryRE,
    input  logic              MemoryWE,
    input  logic [1:0]        SizeOut,
    input  logic              LoadUnsigned,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              BusError,
    output logic              BusReq,
    output logic              BusWE,
    output logic [ADDR_W-1:0] BusAddr,
    output logic [3:0]        BusByteEn,
    output logic [31:0]       BusWData,
    input  logic              BusAck,
    input  logic [31:0]       BusRData
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             unsigned_q;

    logic             request;
    logic             align_fault;
    logic [1:0]       lane_size;
    logic [1:0]       lane_sel;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_load;

    assign request = MemoryRE | MemoryWE;

    // In IDLE the lane unit sees the live request; afterwards the latched one.
    assign lane_size = (state == IDLE) ? SizeOut      : size_q;
    assign lane_sel  = (state == IDLE) ? Address[1:0] : lane_q;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign align_fault = is_misaligned(SizeOut, Address[1:0]);
`else
    assign align_fault = 1'b0;
`endif

    assign Stall = ((state == IDLE) && request) || (state == ISSUE);

    data_mem_lane u_lane (
        .size          (lane_size),
        .lane          (lane_sel),
        .load_unsigned (unsigned_q),
        .store_data    (WriteData),
        .bus_rdata     (BusRData),
        .byte_en       (lane_be),
        .bus_wdata     (lane_wdata),
        .load_data     (lane_load)
    );

    always_ff @(posedge Clock) begin
        // NOTE: state is updated with non-blocking assignments so every branch reads pre-edge values.
        if (Reset) begin
            state      <= IDLE;
            count      <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            ReadData   <= '0;
            BusError   <= 1'b0;
            BusReq     <= 1'b0;
            BusWE      <= 1'b0;
            BusAddr    <= '0;
            BusByteEn  <= '0;
            BusWData   <= '0;
        end else begin
            BusError <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        lane_q     <= Address[1:0];
                        size_q     <= SizeOut;
                        unsigned_q <= LoadUnsigned;
                        if (align_fault) begin
                            state    <= DONE;
                            BusError <= 1'b1;
                            ReadData <= '0;
                        end else begin
                            state     <= ISSUE;
                            count     <= '0;
                            BusReq    <= 1'b1;
                            BusWE     <= MemoryWE;
                            BusAddr   <= {Address[ADDR_W-1:2], 2'b00};
                            BusByteEn <= lane_be;
                            BusWData  <= lane_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (BusAck) begin
                        state     <= DONE;
                        BusReq    <= 1'b0;
                        BusWE     <= 1'b0;
                        BusByteEn <= '0;
                        ReadData  <= BusWE ? 32'h0 : lane_load;
                    end else if (count == CNT_LAST) begin
                        state     <= DONE;
                        BusReq    <= 1'b0;
                        BusWE     <= 1'b0;
                        BusByteEn <= '0;
                        BusError  <= 1'b1;
                        ReadData  <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    // Pipeline advances on this edge, so the held request cannot retrigger.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Responder end of the memory-control signals produced by instruction decode (MemoryRE, MemoryWE, SizeOut).
- Sits in the MEM stage between the pipeline and a word-wide data bus with byte enables.
- Converts byte/half/word loads and stores into aligned bus transactions, then extracts and extends load data.
- Holds the pipeline with Stall until the bus transaction finishes.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for BusAck before the transaction is aborted.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- MemoryRE  in  1  load request from the decoded instruction.
- MemoryWE  in  1  store request from the decoded instruction.
- SizeOut  in  2  access size: 00 byte, 01 half, 10 word, 11 word.
- LoadUnsigned  in  1  1 = zero-extend load data, 0 = sign-extend.
- Address  in  ADDR_W  byte address from the ALU.
- WriteData  in  32  store data, right-justified.
- ReadData  out  32  extended load result.
- Stall  out  1  hold the pipeline.
- BusError  out  1  one-cycle pulse on timeout (and on misalignment when the optional feature is enabled).
- BusReq  out  1  bus request.
- BusWE  out  1  bus write.
- BusAddr  out  ADDR_W  word-aligned address, {Address[ADDR_W-1:2], 2'b00}.
- BusByteEn  out  4  byte-lane enables.
- BusWData  out  32  lane-replicated store data.
- BusAck  in  1  bus completion.
- BusRData  in  32  bus read word.

Behaviour:
- Byte order is little-endian: byte n of a word occupies bits [8n+7:8n]. The lane index is Address[1:0].
- Byte enables:
  - Byte access: 4'b0001 << Address[1:0].
  - Half access: 4'b0011 << {Address[1],1'b0}.
  - Word access: 4'b1111.
- Store data replication: byte = {4{WriteData[7:0]}}; half = {2{WriteData[15:0]}}; word = WriteData.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE: when MemoryRE or MemoryWE is high, Stall=1 combinationally in the same cycle. Latch address, size, unsigned flag, write data and direction, then go to ISSUE.
  - IDLE with both requests high: treated as a store (WE has priority) and the load is dropped.
  - ISSUE: BusReq=1 and all bus outputs held stable until BusAck is sampled high. BusAck high in the first ISSUE cycle is legal. On ack, latch BusRData and go to DONE. Stall=1 throughout.
  - DONE: Stall=0 for exactly one cycle while ReadData is valid. The pipeline advances on that edge; next state is IDLE. The held instruction therefore cannot retrigger.
- Latency: a request seen in cycle 0 with ack in cycle 1 gives DONE in cycle 2. Minimum is 2 stalled cycles.
- Load extraction:
  - Select the byte or half by the latched Address[1:0] / Address[1].
  - Extend to 32 bits, sign or zero per LoadUnsigned.
  - Word loads pass through unchanged.
- ReadData is registered. It holds its last value outside DONE and is 0 after a store.
- Timeout:
  - The counter runs in ISSUE only.
  - When it reaches TIMEOUT_CYCLES-1 without ack: drop BusReq, pulse BusError, set ReadData=0, go to DONE.
  - The counter clears on entering ISSUE. Its width is $clog2(TIMEOUT_CYCLES).
- Reset (including mid-transaction): state IDLE, counter 0, and all outputs 0, namely Stall, BusError, BusReq, BusWE, BusAddr, BusByteEn, BusWData and ReadData.
  - A bus ack arriving after such a reset is ignored.
- When idle, the bus outputs read 0 apart from BusAddr/BusWData, which hold their last values.

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHECK_EN.
- When defined: a half access with Address[0]=1, or a word access with Address[1:0]!=0, never asserts BusReq. IDLE goes straight to DONE with BusError pulsed and ReadData=0; Stall is 1 for one cycle.
- When undefined: the low address bits are ignored for alignment. A misaligned half uses lanes {Address[1],0}, and a word uses all lanes.

Decomposition:
- Shared package holds:
  - Size encodings: SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
  - FSM state typedef: IDLE, ISSUE, DONE.
  - Byte-enable patterns.
- One sub-module: data_mem_lane, a combinational byte-enable/store-replicate/load-extract unit, so the lane logic can be tested alone.

Test Plan:
- SB: Address=0x1003, WriteData=0x000000AB, ack after 1 cycle -> BusByteEn=4'b1000, BusWData=0xABABABAB, BusAddr=0x1000, Stall high 2 cycles.
- LB signed: Address=0x2001, BusRData=0x1234_80FF -> ReadData=0xFFFFFF80. The same access with LoadUnsigned=1 gives 0x00000080.
- LH: Address=0x2002, BusRData=0x8001_0000 -> ReadData=0xFFFF8001. LW at 0x2000 returns 0x80010000 unchanged.
- BusAck never asserted, TIMEOUT_CYCLES=8 -> BusReq drops after 8 ISSUE cycles, BusError pulses once, ReadData=0, Stall falls.
- Reset asserted during ISSUE, then a late BusAck -> all outputs 0, state IDLE, ack ignored. The next MemoryRE starts a fresh transaction.
- With DATA_MEM_ALIGN_CHECK_EN: LW at 0x3002 -> no BusReq, BusError pulse, Stall for 1 cycle. Without the macro: BusByteEn=4'b1111 at BusAddr=0x3000.
